hsv_core_mem_issue_ctrl: RTL and testbench

- Shares the single memory bus request channel among NUM_REQ requesters (load port, store port, ...) using round-robin arbitration.
- Tracks in-flight transactions with an internal outstanding counter and throttles issue at MAX_OUTSTANDING.
- On pipeline flush, stops issuing and drains in-flight responses, marking them for discard, before resuming.
- Sits between the mem-unit request ports and the bus master.

---
 rtl/hsv_core_pkg.sv | 22 ++
 rtl/hsv_core_mem_rr_arbiter.sv | 51 +++++
 rtl/hsv_core_mem_issue_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hsv_core_mem_issue_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_core_pkg.sv
// rtl/hsv_core_pkg.sv - shared types and constants for the hsv core memory issue path
package hsv_core_pkg;

  // Issue controller modes: normal issue, or waiting for flushed work to retire
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } mem_issue_state_t;

  // Default in-flight transaction limit for the memory bus
  localparam int HSV_MEM_MAX_OUTSTANDING = 4;

  // Requester slots on the shared request channel
  localparam int MEM_REQ_LOAD  = 0;
  localparam int MEM_REQ_STORE = 1;

  // Index width for n requesters, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hsv_core_mem_rr_arbiter.sv
// rtl/hsv_core_mem_rr_arbiter.sv - round-robin (or fixed-priority with HSV_CORE_MEM_FIXED_PRIO_EN) grant with lock override
module hsv_core_mem_rr_arbiter
  import hsv_core_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_lock,
  input  logic [IDX_W-1:0]   i_lock_idx,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  int               w_best;
  int               w_dist;
  logic [IDX_W-1:0] w_idx;

`ifdef HSV_CORE_MEM_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;
`endif

  // Pick the valid requester closest to the start point; a held grant overrides the search
  always_comb begin
    w_best = NUM_REQ;
    w_dist = 0;
    w_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_req[i]) begin
`ifdef HSV_CORE_MEM_FIXED_PRIO_EN
        w_dist = i;
`else
        w_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + NUM_REQ - int'(i_ptr));
`endif
        if (w_dist < w_best) begin
          w_best = w_dist;
          w_idx  = IDX_W'(i);
        end
      end
    end
    if (i_lock) begin
      w_idx = i_lock_idx;
    end
  end

  assign o_idx   = w_idx;
  assign o_grant = (|i_req) ? (NUM_REQ'(1) << w_idx) : '0;

endmodule

// File: rtl/hsv_core_mem_issue_ctrl.sv
// rtl/hsv_core_mem_issue_ctrl.sv - shared memory bus issue control with outstanding throttle and flush drain (option: HSV_CORE_MEM_FIXED_PRIO_EN)
module hsv_core_mem_issue_ctrl
  import hsv_core_pkg::*;
#(
  parameter int  NUM_REQ         = 2,
  parameter int  PAYLOAD_W       = 64,
  parameter int  MAX_OUTSTANDING = HSV_MEM_MAX_OUTSTANDING,
  localparam int CNT_IDX_W       = idx_width(NUM_REQ),
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clk_core,
  input  logic                         rst_core_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         bus_valid,
  input  logic                         bus_ready,
  output logic [PAYLOAD_W-1:0]         bus_data,
  output logic [CNT_IDX_W-1:0]         bus_sel,
  input  logic                         rsp_valid,
  output logic                         rsp_drop,
  input  logic                         flush,
  output logic [OUT_W-1:0]             outstanding,
  output logic                         drained
);

  mem_issue_state_t     r_state;
  mem_issue_state_t     w_state_nxt;
  logic [OUT_W-1:0]     r_outstanding;
  logic [OUT_W-1:0]     w_out_nxt;
  logic                 r_lock;
  logic [CNT_IDX_W-1:0] r_lock_idx;
  logic [CNT_IDX_W-1:0] w_ptr;
  logic [CNT_IDX_W-1:0] w_idx;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_can_issue;
  logic                 w_bus_valid;
  logic                 w_fire;
  logic                 w_rsp_ret;
  logic                 w_rsp_drop;
  logic                 w_drained;
  logic [PAYLOAD_W-1:0] w_bus_data;

  hsv_core_mem_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (CNT_IDX_W)
  ) u_arb (
    .i_req      (req_valid),
    .i_ptr      (w_ptr),
    .i_lock     (r_lock),
    .i_lock_idx (r_lock_idx),
    .o_grant    (w_grant),
    .o_idx      (w_idx)
  );

  // Issue only below the credit limit and never in a flush cycle; reset forces the request low
  assign w_can_issue = (r_outstanding < OUT_W'(MAX_OUTSTANDING)) & ~flush;
  assign w_bus_valid = rst_core_n & (r_state == RUN) & w_can_issue & (|req_valid);
  assign w_fire      = w_bus_valid & bus_ready;
  // A response with nothing in flight is ignored so the count cannot wrap
  assign w_rsp_ret   = rsp_valid & (r_outstanding != '0);

  // Steer the granted requester's payload onto the bus
  always_comb begin
    w_bus_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == CNT_IDX_W'(i)) begin
        w_bus_data = req_data[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  // Net in-flight change: accepted request adds one, retired response removes one
  always_comb begin
    w_out_nxt = r_outstanding;
    if (w_fire && !w_rsp_ret) begin
      w_out_nxt = r_outstanding + 1'b1;
    end else if (!w_fire && w_rsp_ret) begin
      w_out_nxt = r_outstanding - 1'b1;
    end
  end

  // Mode selection and the mode-dependent response/idle flags
  always_comb begin
    w_state_nxt = r_state;
    w_rsp_drop  = 1'b0;
    w_drained   = 1'b0;
    case (r_state)
      RUN: begin
        w_drained = (r_outstanding == '0);
        if (flush && (w_out_nxt != '0)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_rsp_drop = rsp_valid;
        if (w_out_nxt == '0) begin
          w_state_nxt = RUN;
        end
      end
    endcase
  end

  // Mode register
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // In-flight counter; flush leaves it alone because those responses still come back
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_outstanding <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
    end
  end

  // Hold the grant while the bus stalls an offered request; a flush withdraws it
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      r_lock     <= w_bus_valid & ~bus_ready;
      r_lock_idx <= w_idx;
    end
  end

`ifndef HSV_CORE_MEM_FIXED_PRIO_EN
  logic [CNT_IDX_W-1:0] r_rr_ptr;

  // Move the round-robin start point just past whoever won the bus
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_rr_ptr <= '0;
    end else if (w_fire) begin
      r_rr_ptr <= (w_idx == CNT_IDX_W'(NUM_REQ - 1)) ? '0 : (w_idx + 1'b1);
    end
  end

  assign w_ptr = r_rr_ptr;
`else
  assign w_ptr = '0;
`endif

  assign bus_valid   = w_bus_valid;
  assign bus_data    = w_bus_data;
  assign bus_sel     = w_idx;
  assign req_ready   = w_grant & {NUM_REQ{w_fire}};
  assign rsp_drop    = w_rsp_drop;
  assign drained     = w_drained;
  assign outstanding = r_outstanding;

`ifndef SYNTHESIS
  a_no_rsp_underflow: assert property (@(posedge clk_core) disable iff (!rst_core_n)
    !(rsp_valid && (r_outstanding == '0)));
`endif

endmodule

// File: tb/tb_hsv_core_mem_issue_ctrl.sv
// tb/tb_hsv_core_mem_issue_ctrl.sv - self-checking bench for hsv_core_mem_issue_ctrl
module tb_hsv_core_mem_issue_ctrl;

  localparam int NREQ = 2;
  localparam int PW   = 64;
  localparam int MAXO = 4;

  logic           clk_core = 1'b0;
  logic           rst_core_n = 1'b0;
  logic [1:0]     req_valid = '0;
  logic [127:0]   req_data = '0;
  logic [1:0]     req_ready;
  logic           bus_valid;
  logic           bus_ready = 1'b0;
  logic [63:0]    bus_data;
  logic [0:0]     bus_sel;
  logic           rsp_valid = 1'b0;
  logic           rsp_drop;
  logic           flush = 1'b0;
  logic [2:0]     outstanding;
  logic           drained;

  hsv_core_mem_issue_ctrl #(
    .NUM_REQ         (NREQ),
    .PAYLOAD_W       (PW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_core    (clk_core),
    .rst_core_n  (rst_core_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_data    (bus_data),
    .bus_sel     (bus_sel),
    .rsp_valid   (rsp_valid),
    .rsp_drop    (rsp_drop),
    .flush       (flush),
    .outstanding (outstanding),
    .drained     (drained)
  );

  always #5 clk_core = ~clk_core;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state: in-flight count, draining flag, next round-robin start, held grant
  int m_cnt;
  bit m_drain;
  int m_next;
  int m_hold;

  // outputs sampled at the last step
  logic        s_valid;
  logic [0:0]  s_sel;
  logic [1:0]  s_ready;
  logic [63:0] s_data;
  logic [2:0]  s_out;
  logic        s_drop;
  logic        s_drained;

  typedef struct {
    logic [1:0] rv;
    logic       rdy;
    logic       rsp;
    logic       fl;
    logic       ev;
    int         sel;
    logic [1:0] er;
    int         out;
    logic       drop;
    logic       drn;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_cnt   = 0;
    m_drain = 0;
    m_next  = 0;
    m_hold  = -1;
  endfunction

  function automatic int model_grant(input logic [1:0] rv);
    int idx;
    if (m_hold >= 0) return m_hold;
    for (int k = 0; k < NREQ; k++) begin
`ifdef HSV_CORE_MEM_FIXED_PRIO_EN
      idx = k;
`else
      idx = (m_next + k) % NREQ;
`endif
      if (rv[idx]) return idx;
    end
    return 0;
  endfunction

  // one clock: drive at posedge+1, check against the model at negedge, advance the model
  task automatic step(input logic [1:0] rv, input logic rdy, input logic rsp, input logic fl);
    int         g;
    bit         ev;
    bit         fire;
    bit         ret;
    logic [1:0] er;
    for (int i = 0; i < NREQ; i++) begin
      if (i != m_hold) req_data[i*PW +: PW] = {$urandom, $urandom};
    end
    req_valid = rv;
    bus_ready = rdy;
    rsp_valid = rsp;
    flush     = fl;
    g  = model_grant(rv);
    ev = !m_drain && (m_cnt < MAXO) && !fl && (rv != 2'b00);
    er = (ev && rdy) ? (2'b01 << g) : 2'b00;
    @(negedge clk_core);
    s_valid = bus_valid; s_sel = bus_sel; s_ready = req_ready; s_data = bus_data;
    s_out = outstanding; s_drop = rsp_drop; s_drained = drained;
    chk("bus_valid", bus_valid, ev);
    chk("req_ready", req_ready, er);
    if (ev) begin
      chk("bus_sel", bus_sel, g);
      chk("bus_data", bus_data, req_data[g*PW +: PW]);
    end
    chk("outstanding", outstanding, m_cnt);
    chk("rsp_drop", rsp_drop, m_drain && rsp);
    chk("drained", drained, !m_drain && (m_cnt == 0));
    @(posedge clk_core);
    #1;
    fire  = ev && rdy;
    ret   = rsp && (m_cnt > 0);
    m_cnt = m_cnt + int'(fire) - int'(ret);
    if (fire) m_next = (g + 1) % NREQ;
    m_hold = (ev && !rdy) ? g : -1;
    if (!m_drain) m_drain = fl && (m_cnt != 0);
    else          m_drain = (m_cnt != 0);
  endtask

  task automatic do_reset();
    rst_core_n = 1'b0;
    req_valid = '0; bus_ready = 1'b0; rsp_valid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk_core);
    #1;
    rst_core_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [63:0] d1;
    logic [1:0]  rv;
    logic        rdy;
    logic        rsp;
    logic        fl;

    //            rv    rdy   rsp   fl    ev    sel er     out drop  drn
    tbl[0]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 0, 2'b01, 0, 1'b0, 1'b1};
    tbl[1]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1, 2'b10, 1, 1'b0, 1'b0};
    tbl[2]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 0, 2'b01, 1, 1'b0, 1'b0};
    tbl[3]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1, 2'b10, 1, 1'b0, 1'b0};
    tbl[4]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 0, 2'b01, 2, 1'b0, 1'b0};
    tbl[5]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1, 2'b10, 3, 1'b0, 1'b0};
    tbl[6]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2'b00, 4, 1'b0, 1'b0};
    tbl[7]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2'b00, 4, 1'b0, 1'b0};
    tbl[8]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 0, 2'b01, 3, 1'b0, 1'b0};
    tbl[9]  = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2'b00, 4, 1'b0, 1'b0};
    tbl[10] = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 2'b00, 3, 1'b0, 1'b0};
    tbl[11] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2'b00, 3, 1'b1, 1'b0};
    tbl[12] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 0, 2'b00, 2, 1'b1, 1'b0};
    tbl[13] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2'b00, 1, 1'b1, 1'b0};
    tbl[14] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1, 2'b10, 0, 1'b0, 1'b1};
    tbl[15] = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2'b00, 1, 1'b0, 1'b0};
    tbl[16] = '{2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2'b00, 0, 1'b0, 1'b1};
    tbl[17] = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 0, 2'b01, 0, 1'b0, 1'b1};
    tbl[18] = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2'b00, 1, 1'b0, 1'b0};
    tbl[19] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1, 2'b10, 0, 1'b0, 1'b1};
    tbl[20] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 0, 2'b01, 1, 1'b0, 1'b0};
    tbl[21] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1, 2'b10, 2, 1'b0, 1'b0};
    tbl[22] = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 0, 2'b00, 2, 1'b0, 1'b0};
    tbl[23] = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2'b00, 1, 1'b1, 1'b0};
    tbl[24] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 0, 2'b01, 0, 1'b0, 1'b1};

    // reset state, with both requesters already asking
    req_valid = 2'b11; bus_ready = 1'b1; rsp_valid = 1'b0;
    #3;
    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_drop", rsp_drop, 1'b0);
    chk("rst_drained", drained, 1'b1);
    chk("rst_outstanding", outstanding, 3'd0);
    do_reset();

`ifndef HSV_CORE_MEM_FIXED_PRIO_EN
    // fairness, throttle, drain and simultaneous update vectors
    for (int r = 0; r < 25; r++) begin
      step(tbl[r].rv, tbl[r].rdy, tbl[r].rsp, tbl[r].fl);
      chk($sformatf("tbl%0d_valid", r), s_valid, tbl[r].ev);
      if (tbl[r].ev) chk($sformatf("tbl%0d_sel", r), s_sel, tbl[r].sel);
      chk($sformatf("tbl%0d_ready", r), s_ready, tbl[r].er);
      chk($sformatf("tbl%0d_out", r), s_out, tbl[r].out);
      chk($sformatf("tbl%0d_drop", r), s_drop, tbl[r].drop);
      chk($sformatf("tbl%0d_drained", r), s_drained, tbl[r].drn);
    end
`else
    // fixed priority: requester 0 always wins
    for (int r = 0; r < 4; r++) begin
      step(2'b11, 1'b1, (r > 0), 1'b0);
      chk("fixed_sel", s_sel, 1'b0);
      chk("fixed_ready", s_ready, 2'b01);
    end
`endif

    // backpressure lock: requester 1 held while requester 0 joins
    do_reset();
    step(2'b10, 1'b0, 1'b0, 1'b0);
    d1 = req_data[127:64];
    chk("lock_first_sel", s_sel, 1'b1);
    for (int r = 0; r < 2; r++) begin
      step(2'b11, 1'b0, 1'b0, 1'b0);
      chk("lock_hold_sel", s_sel, 1'b1);
      chk("lock_hold_data", s_data, d1);
      chk("lock_hold_ready", s_ready, 2'b00);
    end
    step(2'b11, 1'b1, 1'b0, 1'b0);
    chk("lock_fire_ready", s_ready, 2'b10);
    chk("lock_fire_data", s_data, d1);
    step(2'b11, 1'b1, 1'b1, 1'b0);
    chk("lock_next_sel", s_sel, 1'b0);

    // asynchronous reset while draining
    do_reset();
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b1);
    req_valid = 2'b11; bus_ready = 1'b1; rsp_valid = 1'b1; flush = 1'b0;
    #1;
    chk("drain_drop_before_rst", rsp_drop, 1'b1);
    #1;
    rst_core_n = 1'b0;
    #1;
    chk("arst_outstanding", outstanding, 3'd0);
    chk("arst_drained", drained, 1'b1);
    chk("arst_bus_valid", bus_valid, 1'b0);
    chk("arst_rsp_drop", rsp_drop, 1'b0);
    chk("arst_req_ready", req_ready, 2'b00);
    rsp_valid = 1'b0;
    @(posedge clk_core);
    #1;
    rst_core_n = 1'b1;
    model_reset();
    step(2'b11, 1'b1, 1'b0, 1'b0);
    chk("arst_first_sel", s_sel, 1'b0);

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rv = 2'($urandom_range(0, 3));
      if (m_hold >= 0) rv[m_hold] = 1'b1;
      rdy = ($urandom_range(0, 3) != 0);
      rsp = (m_cnt > 0) && ($urandom_range(0, 1) == 1);
      fl  = ($urandom_range(0, 19) == 0);
      step(rv, rdy, rsp, fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
